spi_duty_loader: RTL and testbench
==================================

# spi_duty_loader

SPI-slave front end that sits directly upstream of the PWM channel bank in `top`. It receives the host's SPI frames (nCS/SCK/MOSI, mode 0, MSB first) in the system clock domain and assembles one duty byte per channel into shadow registers. On frame end it commits all channel duties to the PWM bank atomically, so a PWM never sees a half-written set. SCK is never used as a clock.

## Interface
Parameters:
- `pwm_width`, 5: duty bits per channel; legal range 1..8.
- `num_pwm`, 3: number of channels (bytes per frame); legal range 1..16.

Ports:
- `clk` in 1: system clock (50 MHz in the platform).
- `rst` in 1: reset; synchronous, active-low.
- `nCS` in 1: SPI chip select, active low; asynchronous to `clk`.
- `SCK` in 1: SPI clock, idle low; asynchronous to `clk`.
- `MOSI` in 1: SPI data; asynchronous to `clk`.
- `duty` out num_pwm*pwm_width: committed duties; channel k occupies bits [k*pwm_width +: pwm_width].
- `duty_update` out 1: one-cycle pulse in the cycle `duty` takes a newly committed value.
- `frame_err` out 1: one-cycle pulse when a frame ends with fewer than num_pwm complete bytes.

## Operation
- Input conditioning: `nCS`, `SCK` and `MOSI` each pass through an identical 2-flop synchronizer. Edge detection uses one further register stage on synced `SCK` and `nCS`. MOSI is taken from the same-depth synced stage, so the sampled bit is the one present at the SCK rising edge.
- State machine:
  - WAIT_IDLE: entered on reset. Leaves for IDLE only once synced nCS = 1, which prevents joining a frame mid-way.
  - IDLE: synced nCS falling edge -> SHIFT. Clears bit counter (3 bits), byte counter and shadow registers.
  - SHIFT:
    - Each SCK rising edge shifts MOSI into an 8-bit shift register, MSB first.
    - On the 8th bit, byte bits [pwm_width-1:0] load shadow channel `byte_count`, `byte_count` increments, and the bit counter wraps to 0.
    - Bytes with byte_count >= num_pwm are received and discarded. `byte_count` saturates at num_pwm.
    - Synced nCS rising edge -> COMMIT.
  - COMMIT (one cycle):
    - If byte_count == num_pwm, `duty` <= shadow and `duty_update` = 1.
    - Otherwise `duty` is unchanged and `frame_err` = 1.
    - Trailing partial bytes (bit counter != 0) are ignored and do not cause an error on their own.
    - Next state is IDLE.
- SCK edges while nCS is high are ignored. SCK falling edges are ignored.
- The upper (8-pwm_width) bits of each byte are discarded.

## Timing
- Reset values: `duty` = 0, `duty_update` = 0, `frame_err` = 0. Synchronizers reset to nCS = 1, SCK = 0, MOSI = 0. State WAIT_IDLE.
- Reset asserted mid-frame: shadow is discarded and `duty` returns to 0 on the next clk. After reset, no commit occurs until a fresh nCS fall/rise pair is seen.
- SPI input requirements:
  - SCK high and low phases each >= 2 clk periods (the bench uses 50 ns = 2.5 clk).
  - MOSI stable >= 2 clk periods before and 1 clk period after each SCK rising edge.
  - nCS falls >= 3 clk periods before the first SCK rising edge, and rises after the last SCK falling edge.
- Latency from SCK rising pad edge to bit captured: 3 clk, with ±1 for synchronizer phase.
- Latency from nCS rising pad edge to `duty` / `duty_update`: 4 clk (2 sync + 1 edge detect + COMMIT register), ±1 for phase.
- `duty_update` and `frame_err` are mutually exclusive and never exceed 1 cycle.
- Back-to-back frames: nCS high time >= 3 clk periods guarantees COMMIT completes before the next IDLE falling-edge detect.

## Test plan
Defaults pwm_width = 5, num_pwm = 3; bench SCK period 100 ns, clk period 20 ns.
- Frame 0x24, 0x81, 0x09 -> one `duty_update` pulse; `duty` = 0x2424 (ch0 = 4, ch1 = 1, ch2 = 9); `frame_err` stays 0.
- 2-byte frame 0xFF, 0xFF after the above -> one `frame_err` pulse; `duty` stays 0x2424; no `duty_update`.
- 6-byte frame 0x1F, 0x00, 0x10, 0xAA, 0xBB, 0xCC -> `duty` = 0x401F; extra bytes ignored; single update pulse.
- 3 bytes 0x01, 0x02, 0x03 followed by 4 extra bits before nCS rises -> `duty` = 0x0C41, update pulse, no error.
- `rst` driven low in the middle of byte 2 with nCS held low, then released -> `duty` = 0 immediately; no commit on that frame's nCS rise; the following full frame commits normally.
- SCK toggled 16 times with nCS high -> `duty`, `duty_update` and `frame_err` unchanged.

Source files
------------

// File: rtl/spi_duty_loader.sv
// SPI-slave (mode 0, MSB first) that collects one duty byte per PWM channel into
// shadow registers and commits the whole set atomically when nCS rises.
`timescale 1ns/1ps

module spi_duty_loader #(
  parameter int pwm_width = 5,
  parameter int num_pwm   = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         nCS,
  input  logic                         SCK,
  input  logic                         MOSI,
  output logic [num_pwm*pwm_width-1:0] duty,
  output logic                         duty_update,
  output logic                         frame_err
);

  localparam int dw    = num_pwm * pwm_width;
  localparam int cnt_w = $clog2(num_pwm + 1);
  localparam logic [cnt_w-1:0] full_count = cnt_w'(num_pwm);

  localparam logic [1:0] WAIT_IDLE = 2'd0;
  localparam logic [1:0] IDLE      = 2'd1;
  localparam logic [1:0] SHIFT     = 2'd2;
  localparam logic [1:0] COMMIT    = 2'd3;

  logic ncs_s1, ncs_s2, ncs_s3;
  logic sck_s1, sck_s2, sck_s3;
  logic mosi_s1, mosi_s2;
  logic [1:0] primed;

  logic [1:0]           state;
  logic [2:0]           bit_cnt;
  logic [cnt_w-1:0]     byte_count;
  logic [pwm_width-1:0] shift_reg;
  logic [pwm_width-1:0] shift_next;
  logic [dw-1:0]        shadow;

  logic sck_rise, ncs_fall, ncs_rise;

  // NOTE: every register here uses <= so all flops sample pre-edge values; with
  // blocking assignments the synchronizer stages would collapse into one.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ncs_s1  <= 1'b1;
      ncs_s2  <= 1'b1;
      ncs_s3  <= 1'b1;
      sck_s1  <= 1'b0;
      sck_s2  <= 1'b0;
      sck_s3  <= 1'b0;
      mosi_s1 <= 1'b0;
      mosi_s2 <= 1'b0;
      primed  <= 2'b00;
    end else begin
      ncs_s1  <= nCS;
      ncs_s2  <= ncs_s1;
      ncs_s3  <= ncs_s2;
      sck_s1  <= SCK;
      sck_s2  <= sck_s1;
      sck_s3  <= sck_s2;
      mosi_s1 <= MOSI;
      mosi_s2 <= mosi_s1;
      primed  <= {primed[0], 1'b1};
    end
  end

  // Only the low pwm_width bits of a byte are kept, so the shift register holds just those.
  always_comb begin
    sck_rise   = sck_s2 & ~sck_s3;
    ncs_fall   = ~ncs_s2 & ncs_s3;
    ncs_rise   = ncs_s2 & ~ncs_s3;
    shift_next = pwm_width'({shift_reg, mosi_s2});
  end

  // The synchronizers reset to nCS high, so a pad held low through reset would
  // otherwise look like a fresh falling edge; primed waits until the sync chain
  // carries real pad values before trusting nCS.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= WAIT_IDLE;
      bit_cnt     <= 3'd0;
      byte_count  <= '0;
      shift_reg   <= '0;
      shadow      <= '0;
      duty        <= '0;
      duty_update <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      duty_update <= 1'b0;
      frame_err   <= 1'b0;
      case (state)
        WAIT_IDLE: begin
          if (primed[1] && ncs_s2) state <= IDLE;
        end
        IDLE: begin
          if (ncs_fall) begin
            state      <= SHIFT;
            bit_cnt    <= 3'd0;
            byte_count <= '0;
            shadow     <= '0;
          end
        end
        SHIFT: begin
          if (ncs_rise) begin
            state <= COMMIT;
          end else if (sck_rise) begin
            shift_reg <= shift_next;
            bit_cnt   <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7 && byte_count != full_count) begin
              for (int k = 0; k < num_pwm; k++) begin
                if (byte_count == cnt_w'(k)) shadow[k*pwm_width +: pwm_width] <= shift_next;
              end
              byte_count <= byte_count + cnt_w'(1);
            end
          end
        end
        COMMIT: begin
          state <= IDLE;
          if (byte_count == full_count) begin
            duty        <= shadow;
            duty_update <= 1'b1;
          end else begin
            frame_err <= 1'b1;
          end
        end
        default: state <= WAIT_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_duty_loader.sv
// Bench for spi_duty_loader: directed frames from the test plan plus random
// frames checked against a byte-queue model of the commit rules.
`timescale 1ns/1ps

module tb_spi_duty_loader;

  localparam int W  = 5;
  localparam int N  = 3;
  localparam int DW = W * N;

  logic          clk  = 1'b0;
  logic          rst  = 1'b0;
  logic          nCS  = 1'b1;
  logic          SCK  = 1'b0;
  logic          MOSI = 1'b0;
  logic [DW-1:0] duty;
  logic          duty_update;
  logic          frame_err;

  spi_duty_loader #(.pwm_width(W), .num_pwm(N)) dut (
    .clk(clk), .rst(rst), .nCS(nCS), .SCK(SCK), .MOSI(MOSI),
    .duty(duty), .duty_update(duty_update), .frame_err(frame_err)
  );

  always #10 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  int upd_cnt   = 0;
  int err_cnt   = 0;
  int rule_viol = 0;
  logic [DW-1:0] prev_duty = '0;
  logic prev_upd = 1'b0;
  logic prev_err = 1'b0;

  // Model state: committed duty and how many updates / errors the rules predict.
  logic [DW-1:0] exp_duty = '0;
  int model_upd = 0;
  int model_err = 0;
  logic [7:0] tx[$];

  always @(negedge clk) begin
    if (duty_update) upd_cnt++;
    if (frame_err) err_cnt++;
    if (duty_update && frame_err) rule_viol++;
    if ((duty_update && prev_upd) || (frame_err && prev_err)) rule_viol++;
    if (rst && (duty !== prev_duty) && !duty_update) rule_viol++;
    prev_duty = duty;
    prev_upd  = duty_update;
    prev_err  = frame_err;
  end

  task automatic spi_bits(input logic [7:0] b, input int nbits);
    for (int i = 7; i > 7 - nbits; i--) begin
      MOSI = b[i];
      #50 SCK = 1'b1;
      #50 SCK = 1'b0;
    end
  endtask

  task automatic send_frame(input int extra);
    nCS = 1'b0;
    #100;
    foreach (tx[i]) spi_bits(tx[i], 8);
    if (extra > 0) spi_bits(8'($urandom), extra);
    #50 nCS = 1'b1;
    if (tx.size() >= N) begin
      for (int k = 0; k < N; k++) exp_duty[k*W +: W] = tx[k][W-1:0];
      model_upd++;
    end else begin
      model_err++;
    end
    #80;
  endtask

  task automatic settle();
    repeat (10) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_assert++;
    if (duty !== '0) begin n_fail++; $display("FAIL reset_duty: got %h expected 0", duty); end
    n_assert++;
    if (duty_update !== 1'b0) begin n_fail++; $display("FAIL reset_update: got %b expected 0", duty_update); end
    n_assert++;
    if (frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b expected 0", frame_err); end
    exp_duty = '0;
    @(negedge clk) rst = 1'b1;
    repeat (5) @(posedge clk);
  endtask

  task automatic test_basic();
    int u0 = upd_cnt, e0 = err_cnt;
    tx = '{8'h24, 8'h81, 8'h09};
    send_frame(0);
    settle();
    n_assert++;
    if (upd_cnt - u0 != 1) begin n_fail++; $display("FAIL basic_updates: got %0d expected 1", upd_cnt - u0); end
    n_assert++;
    if (err_cnt - e0 != 0) begin n_fail++; $display("FAIL basic_errors: got %0d expected 0", err_cnt - e0); end
    n_assert++;
    if (duty !== 15'h2424) begin n_fail++; $display("FAIL basic_duty: got %h expected 2424", duty); end
  endtask

  task automatic test_short();
    int u0 = upd_cnt, e0 = err_cnt;
    tx = '{8'hFF, 8'hFF};
    send_frame(0);
    settle();
    n_assert++;
    if (upd_cnt - u0 != 0) begin n_fail++; $display("FAIL short_updates: got %0d expected 0", upd_cnt - u0); end
    n_assert++;
    if (err_cnt - e0 != 1) begin n_fail++; $display("FAIL short_errors: got %0d expected 1", err_cnt - e0); end
    n_assert++;
    if (duty !== 15'h2424) begin n_fail++; $display("FAIL short_duty: got %h expected 2424", duty); end
  endtask

  task automatic test_long();
    int u0 = upd_cnt, e0 = err_cnt;
    tx = '{8'h1F, 8'h00, 8'h10, 8'hAA, 8'hBB, 8'hCC};
    send_frame(0);
    settle();
    n_assert++;
    if (upd_cnt - u0 != 1) begin n_fail++; $display("FAIL long_updates: got %0d expected 1", upd_cnt - u0); end
    n_assert++;
    if (err_cnt - e0 != 0) begin n_fail++; $display("FAIL long_errors: got %0d expected 0", err_cnt - e0); end
    n_assert++;
    if (duty !== 15'h401F) begin n_fail++; $display("FAIL long_duty: got %h expected 401f", duty); end
  endtask

  task automatic test_partial_tail();
    int u0 = upd_cnt, e0 = err_cnt;
    tx = '{8'h01, 8'h02, 8'h03};
    send_frame(4);
    settle();
    n_assert++;
    if (upd_cnt - u0 != 1) begin n_fail++; $display("FAIL tail_updates: got %0d expected 1", upd_cnt - u0); end
    n_assert++;
    if (err_cnt - e0 != 0) begin n_fail++; $display("FAIL tail_errors: got %0d expected 0", err_cnt - e0); end
    n_assert++;
    if (duty !== 15'h0C41) begin n_fail++; $display("FAIL tail_duty: got %h expected 0c41", duty); end
  endtask

  task automatic test_idle_sck();
    int u0 = upd_cnt, e0 = err_cnt;
    for (int i = 0; i < 16; i++) begin
      MOSI = 1'($urandom);
      #50 SCK = ~SCK;
    end
    settle();
    n_assert++;
    if (upd_cnt - u0 != 0) begin n_fail++; $display("FAIL idle_updates: got %0d expected 0", upd_cnt - u0); end
    n_assert++;
    if (err_cnt - e0 != 0) begin n_fail++; $display("FAIL idle_errors: got %0d expected 0", err_cnt - e0); end
    n_assert++;
    if (duty !== 15'h0C41) begin n_fail++; $display("FAIL idle_duty: got %h expected 0c41", duty); end
  endtask

  task automatic test_random();
    for (int f = 0; f < 10; f++) begin
      int u0 = upd_cnt, e0 = err_cnt, mu0 = model_upd, me0 = model_err;
      int nbytes = $urandom_range(0, 5);
      tx.delete();
      for (int b = 0; b < nbytes; b++) tx.push_back(8'($urandom));
      send_frame($urandom_range(0, 7));
      settle();
      n_assert++;
      if (upd_cnt - u0 != model_upd - mu0) begin
        n_fail++; $display("FAIL rand%0d_updates: got %0d expected %0d", f, upd_cnt - u0, model_upd - mu0);
      end
      n_assert++;
      if (err_cnt - e0 != model_err - me0) begin
        n_fail++; $display("FAIL rand%0d_errors: got %0d expected %0d", f, err_cnt - e0, model_err - me0);
      end
      n_assert++;
      if (duty !== exp_duty) begin
        n_fail++; $display("FAIL rand%0d_duty: got %h expected %h", f, duty, exp_duty);
      end
    end
  endtask

  task automatic test_back_to_back();
    int u0 = upd_cnt, e0 = err_cnt;
    tx = '{8'h0A, 8'h0B, 8'h0C};
    send_frame(0);
    tx = '{8'h15, 8'h16, 8'h17};
    send_frame(0);
    settle();
    n_assert++;
    if (upd_cnt - u0 != 2) begin n_fail++; $display("FAIL b2b_updates: got %0d expected 2", upd_cnt - u0); end
    n_assert++;
    if (err_cnt - e0 != 0) begin n_fail++; $display("FAIL b2b_errors: got %0d expected 0", err_cnt - e0); end
    n_assert++;
    if (duty !== 15'h5ED5) begin n_fail++; $display("FAIL b2b_duty: got %h expected 5ed5", duty); end
  endtask

  task automatic test_reset_mid_frame();
    int u0;
    nCS = 1'b0;
    #100;
    spi_bits(8'h11, 8);
    spi_bits(8'h5A, 4);
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1;
    n_assert++;
    if (duty !== '0) begin n_fail++; $display("FAIL midrst_duty_clear: got %h expected 0", duty); end
    exp_duty = '0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    u0 = upd_cnt;
    spi_bits(8'hA0, 4);
    spi_bits(8'h07, 8);
    #50 nCS = 1'b1;
    #80;
    settle();
    n_assert++;
    if (upd_cnt - u0 != 0) begin n_fail++; $display("FAIL midrst_no_commit: got %0d expected 0", upd_cnt - u0); end
    n_assert++;
    if (duty !== '0) begin n_fail++; $display("FAIL midrst_duty_held: got %h expected 0", duty); end
    u0 = upd_cnt;
    tx = '{8'h03, 8'h04, 8'h05};
    send_frame(0);
    settle();
    n_assert++;
    if (upd_cnt - u0 != 1) begin n_fail++; $display("FAIL midrst_next_updates: got %0d expected 1", upd_cnt - u0); end
    n_assert++;
    if (duty !== 15'h1483) begin n_fail++; $display("FAIL midrst_next_duty: got %h expected 1483", duty); end
  endtask

  task automatic test_pulse_rules();
    n_assert++;
    if (rule_viol != 0) begin n_fail++; $display("FAIL pulse_rules: got %0d violations expected 0", rule_viol); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_short();
    test_long();
    test_partial_tail();
    test_idle_sck();
    test_random();
    test_back_to_back();
    test_reset_mid_frame();
    test_pulse_rules();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
